// File: rtl/mem_seq_stage.sv
// Memory-access pipeline stage: executes LW/SW and sequences LM/SM bursts against an
// internal word-addressed data memory, forwarding store data from the MEM/WB bus.
module mem_seq_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 256,
    parameter int NREG      = 8,
    localparam int RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [RW-1:0]     src_reg,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RW-1:0]     dst_reg,
    input  logic [NREG-1:0]   reg_mask,
    input  logic              wb_valid,
    input  logic [RW-1:0]     wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [RW-1:0]     rf_rd_idx,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              stall,
    output logic              out_valid,
    output logic [RW-1:0]     out_reg,
    output logic [DATA_W-1:0] out_data
);

    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                lm_q, lm_d;
    logic                out_valid_q, out_valid_d;
    logic [RW-1:0]       out_reg_q, out_reg_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic                xfer_en_s;
    logic                xfer_lm_s;
    logic [RW-1:0]       xfer_reg_s;
    logic [ADDR_W-1:0]   xfer_addr_s;
    logic [NREG-1:0]     rem_mask_s;
    logic                mem_we_s;
    logic [MW-1:0]       mem_wa_s;
    logic [DATA_W-1:0]   mem_wd_s;

    function automatic logic [RW-1:0] lowest_bit(input logic [NREG-1:0] m);
        logic [RW-1:0] idx;
        idx = {RW{1'b0}};
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = RW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [NREG-1:0] one_hot(input logic [RW-1:0] idx);
        return {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [MW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        return MW'({1'b0, a} % DEPTH_A);
    endfunction

    // Next-state, burst sequencing, memory write port and writeback selection.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        lm_d        = lm_q;
        out_valid_d = 1'b0;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;
        xfer_en_s   = 1'b0;
        xfer_lm_s   = 1'b0;
        xfer_reg_s  = {RW{1'b0}};
        xfer_addr_s = addr_q;
        rem_mask_s  = {NREG{1'b0}};
        mem_we_s    = 1'b0;
        mem_wa_s    = {MW{1'b0}};
        mem_wd_s    = {DATA_W{1'b0}};
        rf_rd_idx   = {RW{1'b0}};
        stall       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_LW: begin
                            out_valid_d = 1'b1;
                            out_reg_d   = dst_reg;
                            out_data_d  = mem_q[mem_idx(addr)];
                        end
                        OP_SW: begin
                            mem_we_s = 1'b1;
                            mem_wa_s = mem_idx(addr);
                            mem_wd_s = (wb_valid && (wb_reg == src_reg)) ? wb_data : store_data;
                        end
                        OP_LM, OP_SM: begin
                            if (reg_mask != {NREG{1'b0}}) begin
                                xfer_en_s   = 1'b1;
                                xfer_lm_s   = (op == OP_LM);
                                xfer_reg_s  = lowest_bit(reg_mask);
                                xfer_addr_s = addr;
                                rem_mask_s  = reg_mask & ~one_hot(xfer_reg_s);
                                if (rem_mask_s != {NREG{1'b0}}) begin
                                    state_d = S_MULTI;
                                    pend_d  = rem_mask_s;
                                    addr_d  = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                                    lm_d    = xfer_lm_s;
                                    stall   = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULTI: begin
                // Inputs are ignored here; the latched op and pending mask drive the burst.
                xfer_en_s   = 1'b1;
                xfer_lm_s   = lm_q;
                xfer_reg_s  = lowest_bit(pend_q);
                xfer_addr_s = addr_q;
                rem_mask_s  = pend_q & ~one_hot(xfer_reg_s);
                pend_d      = rem_mask_s;
                addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (rem_mask_s != {NREG{1'b0}}) begin
                    stall = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                pend_d  = {NREG{1'b0}};
            end
        endcase

        if (xfer_en_s) begin
            if (xfer_lm_s) begin
                out_valid_d = 1'b1;
                out_reg_d   = xfer_reg_s;
                out_data_d  = mem_q[mem_idx(xfer_addr_s)];
            end else begin
                rf_rd_idx = xfer_reg_s;
                mem_we_s  = 1'b1;
                mem_wa_s  = mem_idx(xfer_addr_s);
                mem_wd_s  = (wb_valid && (wb_reg == xfer_reg_s)) ? wb_data : rf_rd_data;
            end
        end else begin
            rf_rd_idx = {RW{1'b0}};
        end
    end

    // Control state and registered writeback outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pend_q      <= {NREG{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            lm_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_reg_q   <= {RW{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            lm_q        <= lm_d;
            out_valid_q <= out_valid_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
        end
    end

    // Data memory write port; contents survive reset, but a reset cycle writes nothing.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end else begin
            mem_q[mem_wa_s] <= mem_q[mem_wa_s];
        end
    end

    assign out_valid = out_valid_q;
    assign out_reg   = out_reg_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mem_seq_stage.sv
// Self-checking bench for mem_seq_stage: directed steps plus random instructions,
// checked against a transfer-list reference model of the data memory.
module tb_mem_seq_stage;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [2:0]  src_reg;
    logic [15:0] store_data;
    logic [2:0]  dst_reg;
    logic [7:0]  reg_mask;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [2:0]  rf_rd_idx;
    logic [15:0] rf_rd_data;
    logic        stall;
    logic        out_valid;
    logic [2:0]  out_reg;
    logic [15:0] out_data;

    logic [15:0] ref_mem [256];
    int n_assert = 0;
    int n_fail   = 0;

    mem_seq_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .op         (op),
        .addr       (addr),
        .src_reg    (src_reg),
        .store_data (store_data),
        .dst_reg    (dst_reg),
        .reg_mask   (reg_mask),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .rf_rd_idx  (rf_rd_idx),
        .rf_rd_data (rf_rd_data),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_reg    (out_reg),
        .out_data   (out_data)
    );

    // Register file model: Ri holds 0x3000 + i.
    assign rf_rd_data = 16'h3000 + {13'd0, rf_rd_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one instruction and check every cycle it occupies against the transfer list.
    task automatic do_instr(input logic [3:0] o, input logic [15:0] a, input logic [2:0] src,
                            input logic [15:0] sd, input logic [2:0] dst, input logic [7:0] m,
                            input logic wv, input logic [2:0] wr, input logic [15:0] wd);
        int regs[$];
        int k, ncyc, ai;
        logic        exp_v;
        logic [2:0]  exp_r;
        logic [15:0] exp_d;
        regs = {};
        if (o == OP_LM || o == OP_SM) begin
            for (int i = 0; i < 8; i++) if (m[i]) regs.push_back(i);
        end
        k    = regs.size();
        ncyc = (k > 1) ? k : 1;
        in_valid = 1'b1; op = o; addr = a; src_reg = src; store_data = sd;
        dst_reg = dst; reg_mask = m; wb_valid = wv; wb_reg = wr; wb_data = wd;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            ai = (int'(a) + c) % 256;
            chk("stall", {31'd0, stall}, (k > 1 && c < k - 1) ? 32'd1 : 32'd0);
            chk("rf_rd_idx", {29'd0, rf_rd_idx}, (o == OP_SM && k > 0) ? regs[c] : 0);
            exp_v = 1'b0; exp_r = 3'd0; exp_d = 16'd0;
            if (o == OP_LW) begin
                exp_v = 1'b1; exp_r = dst; exp_d = ref_mem[ai];
            end else if (o == OP_SW) begin
                ref_mem[ai] = (wv && wr == src) ? wd : sd;
            end else if (o == OP_LM && k > 0) begin
                exp_v = 1'b1; exp_r = 3'(regs[c]); exp_d = ref_mem[ai];
            end else if (o == OP_SM && k > 0) begin
                ref_mem[ai] = (wv && wr == 3'(regs[c])) ? wd : 16'h3000 + 16'(regs[c]);
            end
            @(posedge clk); #1;
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk("out_reg", {29'd0, out_reg}, {29'd0, exp_r});
                chk("out_data", {16'd0, out_data}, {16'd0, exp_d});
            end
            if (c == 0) begin
                op = 4'($urandom); addr = 16'($urandom); reg_mask = 8'($urandom);
                dst_reg = 3'($urandom); src_reg = 3'($urandom); store_data = 16'($urandom);
            end
        end
        in_valid = 1'b0; op = 4'h0;
    endtask

    initial begin
        logic [3:0] ro;
        reset = 1'b1; in_valid = 1'b0; op = 4'h0; addr = 16'h0; src_reg = 3'd0;
        store_data = 16'h0; dst_reg = 3'd0; reg_mask = 8'h0;
        wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 16'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_out_data", {16'd0, out_data}, 32'd0);
            chk("rst_out_reg", {29'd0, out_reg}, 32'd0);
        end

        // Fill every memory word so the model knows all contents.
        for (int i = 0; i < 256; i++)
            do_instr(OP_SW, 16'(i), 3'($urandom), 16'($urandom), 3'd0, 8'h0,
                     1'($urandom), 3'($urandom), 16'($urandom));

        do_instr(OP_SW, 16'h0010, 3'd3, 16'hBEEF, 3'd0, 8'h0, 1'b0, 3'd0, 16'h0);
        do_instr(OP_LW, 16'h0010, 3'd0, 16'h0, 3'd5, 8'h0, 1'b0, 3'd0, 16'h0);
        chk("sw_lw_data", {16'd0, out_data}, 32'h0000BEEF);
        chk("sw_lw_reg", {29'd0, out_reg}, 32'd5);

        do_instr(OP_SW, 16'h0020, 3'd2, 16'h1111, 3'd0, 8'h0, 1'b1, 3'd2, 16'h2222);
        do_instr(OP_LW, 16'h0020, 3'd0, 16'h0, 3'd1, 8'h0, 1'b0, 3'd0, 16'h0);
        chk("sw_fwd_data", {16'd0, out_data}, 32'h00002222);

        do_instr(OP_SW, 16'h00FE, 3'd0, 16'h000A, 3'd0, 8'h0, 1'b0, 3'd0, 16'h0);
        do_instr(OP_SW, 16'h00FF, 3'd0, 16'h000B, 3'd0, 8'h0, 1'b0, 3'd0, 16'h0);
        do_instr(OP_SW, 16'h0000, 3'd0, 16'h000C, 3'd0, 8'h0, 1'b0, 3'd0, 16'h0);
        do_instr(OP_LM, 16'h00FE, 3'd0, 16'h0, 3'd0, 8'b00100101, 1'b0, 3'd0, 16'h0);
        chk("lm_wrap_last", {16'd0, out_data}, 32'h0000000C);

        do_instr(OP_SM, 16'h0040, 3'd0, 16'h0, 3'd0, 8'b00001010, 1'b1, 3'd3, 16'h9999);
        do_instr(OP_LW, 16'h0040, 3'd0, 16'h0, 3'd4, 8'h0, 1'b0, 3'd0, 16'h0);
        chk("sm_mem40", {16'd0, out_data}, 32'h00003001);
        do_instr(OP_LW, 16'h0041, 3'd0, 16'h0, 3'd4, 8'h0, 1'b0, 3'd0, 16'h0);
        chk("sm_mem41", {16'd0, out_data}, 32'h00009999);

        // LM with a full mask, reset asserted in its third cycle.
        in_valid = 1'b1; op = OP_LM; addr = 16'h0080; reg_mask = 8'hFF; wb_valid = 1'b0;
        @(posedge clk); #1;
        op = 4'h0; reg_mask = 8'h00;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("abort_idle_valid", {31'd0, out_valid}, 32'd0);
        do_instr(OP_LW, 16'h0010, 3'd0, 16'h0, 3'd6, 8'h0, 1'b0, 3'd0, 16'h0);
        chk("post_abort_lw", {16'd0, out_data}, 32'h0000BEEF);
        do_instr(OP_LM, 16'h0033, 3'd0, 16'h0, 3'd0, 8'h00, 1'b0, 3'd0, 16'h0);
        do_instr(OP_SM, 16'h0033, 3'd0, 16'h0, 3'd0, 8'h00, 1'b1, 3'd0, 16'h5555);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0, 5: ro = OP_LW;
                1: ro = OP_SW;
                2: ro = OP_LM;
                3: ro = OP_SM;
                default: begin
                    ro = 4'($urandom);
                    if (ro[3:2] == 2'b01) ro = 4'h0;
                end
            endcase
            do_instr(ro, 16'($urandom), 3'($urandom), 16'($urandom), 3'($urandom),
                     ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                     1'($urandom), 3'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 256; i += 17)
            do_instr(OP_LW, 16'(i), 3'd0, 16'h0, 3'(i), 8'h0, 1'b0, 3'd0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq_stage.md
# mem_seq_stage

Parametrised memory-access pipeline stage with a built-in load/store-multiple sequencer. It sits between the EX/MEM and MEM/WB pipeline registers. It executes LW, SW, LM and SM against an internal word-addressed data memory. Store data is forwarded from the MEM/WB writeback bus, and the block stalls upstream while an LM/SM burst is in progress.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- MEM_DEPTH, 256, data memory words; index = address mod MEM_DEPTH
- NREG, 8, register count; register index width RW = clog2(NREG)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present from EX/MEM
- op  in  4  opcode: LW=0100, SW=0101, LM=0110, SM=0111; any other value passes through
- addr  in  ADDR_W  effective address (LW/SW) or base address (LM/SM)
- src_reg  in  RW  SW source register index
- store_data  in  DATA_W  SW data from the pipeline register
- dst_reg  in  RW  LW destination register
- reg_mask  in  NREG  LM/SM register list; bit i selects Ri
- wb_valid, wb_reg, wb_data  in  1/RW/DATA_W  MEM/WB writeback bus used for forwarding
- rf_rd_idx  out  RW  combinational regfile read index for SM
- rf_rd_data  in  DATA_W  regfile data for rf_rd_idx, same cycle
- stall  out  1  combinational; upstream holds its instruction while high
- out_valid, out_reg, out_data  out  1/RW/DATA_W  registered load writeback to MEM/WB

## Operation
- States: IDLE and MULTI. Internal registers: pending mask, current address, latched op.
- IDLE, in_valid, op=LW:
  - out_data ← mem[addr]
  - out_reg ← dst_reg
  - out_valid ← 1
- IDLE, in_valid, op=SW:
  - mem[addr] ← (wb_valid && wb_reg==src_reg) ? wb_data : store_data
  - out_valid ← 0
- IDLE, in_valid, op=LM/SM, reg_mask≠0:
  - The first transfer uses the lowest set bit i and the address addr, in the accept cycle.
  - If more bits remain, go to MULTI with pending = mask minus bit i and address = addr+1.
- MULTI: each cycle transfers the lowest pending bit j at the current address, clears bit j and increments the address. After the last bit, go to IDLE.
- LM transfer: out_data ← mem[address], out_reg ← j, out_valid ← 1.
- SM transfer:
  - rf_rd_idx = j.
  - mem[address] ← (wb_valid && wb_reg==j) ? wb_data : rf_rd_data.
  - out_valid ← 0.
- rf_rd_idx reads 0 when no SM transfer is active.
- LM/SM with reg_mask=0: no transfer, no stall, out_valid ← 0.
- Other ops, or in_valid=0: out_valid ← 0 and memory is unchanged.
- In MULTI, in_valid and the other inputs are ignored; the latched op and mask govern the burst.
- Address arithmetic is modulo 2^ADDR_W. Memory index = address mod MEM_DEPTH, so wrap-around is silent.
- stall = 1 when either:
  - in IDLE, an accepted LM/SM whose mask has more than one set bit; or
  - in MULTI, more than one pending bit remains.
- Reset:
  - state ← IDLE, pending ← 0
  - out_valid ← 0, out_reg ← 0, out_data ← 0
  - memory contents are not cleared
- Reset asserted mid-burst aborts the burst. Transfers already written stay in memory.

## Timing
- LW: latency 1. Accept at edge n; out_* valid after edge n+1.
- SW: memory is updated at the edge ending the accept cycle. A LW in the next cycle reads the new value.
- LM/SM with k set bits: occupies k cycles (accept cycle plus k-1 MULTI cycles).
  - stall is high for the first k-1 cycles and low in the last.
  - LM writebacks appear on out_* for k consecutive cycles, one cycle after each transfer.
- After the final burst cycle, the next instruction is accepted in the following cycle. There are no bubbles beyond the burst length.
- Forwarding compare uses wb_* in the same cycle as the memory write.

## Test plan
- Reset, then idle for 3 cycles. Required: out_valid=0, stall=0, out_data=0, out_reg=0.
- SW addr=0x0010, src_reg=3, store_data=0xBEEF, wb_valid=0; then LW addr=0x0010, dst_reg=5.
  - Required: out_data=0xBEEF, out_reg=5, out_valid=1 one cycle after LW accept.
- SW src_reg=2, store_data=0x1111, with wb_valid=1, wb_reg=2, wb_data=0x2222; then LW of the same address.
  - Required: LW returns 0x2222.
- Preload mem[0xFE]=0xA, mem[0xFF]=0xB, mem[0x00]=0xC. LM base=0x00FE, mask=8'b00100101, MEM_DEPTH=256.
  - Required: stall high for 2 cycles.
  - Required writebacks (R0,0xA), (R2,0xB), (R5,0xC) on consecutive cycles.
- SM base=0x0040, mask=8'b00001010, rf returns 0x3000+idx, with wb_valid=1, wb_reg=3, wb_data=0x9999.
  - Required: mem[0x40]=0x3001, mem[0x41]=0x9999.
  - Required: rf_rd_idx sequence 1, 3; stall high for 1 cycle.
- LM mask=8'hFF with reset asserted in the 3rd burst cycle.
  - Required: stall=0 and out_valid=0 the cycle after reset.
  - A following LW completes normally.
  - LM with mask=0 causes no stall and no writeback.
